// File: rtl/multicycle_seq.sv
// rtl/multicycle_seq.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer
// Optional memory handshake timeout: `define MULTICYCLE_SEQ_MEM_TIMEOUT_EN
module multicycle_seq #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [6:0]  OpCode,
  input  logic        RUWr_de,
  input  logic        DMWr_de,
  input  logic [1:0]  RuDataWrSrc_de,
  input  logic [4:0]  BrOp_de,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        IRWr_en,
  output logic        PCWr_en,
  output logic        RUWr_en,
  output logic [2:0]  state_o,
  output logic [31:0] instret,
  output logic        trap,
  output logic [1:0]  trap_cause
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'b000,
    S_FETCH  = 3'b001,
    S_DECODE = 3'b010,
    S_EXEC   = 3'b011,
    S_MEM    = 3'b100,
    S_WB     = 3'b101,
    S_TRAP   = 3'b111
  } state_t;

  state_t state;
  logic   legal_op;
  logic   is_mem_op;
  logic   is_branch;
  logic   is_load;
  logic   timeout;
  logic   unused_brop;

  always_comb begin
    legal_op = 1'b0;
    case (OpCode)
      7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b1100011,
      7'b0100011, 7'b1101111, 7'b0110111, 7'b0010111: legal_op = 1'b1;
      default: legal_op = 1'b0;
    endcase
  end

  assign is_mem_op   = (OpCode == 7'b0000011) || (OpCode == 7'b0100011);
  assign is_branch   = (BrOp_de[4:3] == 2'b01);
  assign is_load     = (RuDataWrSrc_de == 2'b01);
  assign unused_brop = ^BrOp_de[2:0];

  assign imem_req = (state == S_FETCH);
  assign dmem_req = (state == S_MEM);
  assign dmem_we  = (state == S_MEM) && DMWr_de;
  assign IRWr_en  = (state == S_FETCH) && imem_ready;
  assign RUWr_en  = (state == S_WB) && RUWr_de;
  // Retirement points: branch from EXEC, store from MEM, everything else from WB.
  assign PCWr_en  = ((state == S_EXEC) && !is_mem_op && is_branch) ||
                    ((state == S_MEM) && dmem_ready && !is_load) ||
                    (state == S_WB);

  assign state_o = state;

`ifdef MULTICYCLE_SEQ_MEM_TIMEOUT_EN
  logic [7:0] wait_cnt;
  logic       waiting;

  assign waiting = ((state == S_FETCH) && !imem_ready) ||
                   ((state == S_MEM) && !dmem_ready);
  assign timeout = waiting && (wait_cnt == 8'(TIMEOUT_CYCLES - 1));

  // Every entry into FETCH/MEM follows a non-waiting cycle, so the count starts at 0.
  always_ff @(posedge clk) begin
    if (!rst_n)       wait_cnt <= 8'd0;
    else if (waiting) wait_cnt <= wait_cnt + 8'd1;
    else              wait_cnt <= 8'd0;
  end
`else
  // Unbounded waits; a zero TIMEOUT_CYCLES is outside the legal range, so this is always 0.
  assign timeout = (TIMEOUT_CYCLES == 0);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      instret    <= 32'd0;
      trap       <= 1'b0;
      trap_cause <= 2'b00;
    end else begin
      if (PCWr_en) instret <= instret + 32'd1;
      case (state)
        S_IDLE:   if (run) state <= S_FETCH;
        S_FETCH: begin
          if (imem_ready) begin
            state <= S_DECODE;
          end else if (timeout) begin
            state      <= S_TRAP;
            trap       <= 1'b1;
            trap_cause <= 2'b10;
          end
        end
        S_DECODE: begin
          if (legal_op) begin
            state <= S_EXEC;
          end else begin
            state      <= S_TRAP;
            trap       <= 1'b1;
            trap_cause <= 2'b01;
          end
        end
        S_EXEC: begin
          if (is_mem_op)      state <= S_MEM;
          else if (is_branch) state <= run ? S_FETCH : S_IDLE;
          else                state <= S_WB;
        end
        S_MEM: begin
          if (dmem_ready) begin
            if (is_load) state <= S_WB;
            else         state <= run ? S_FETCH : S_IDLE;
          end else if (timeout) begin
            state      <= S_TRAP;
            trap       <= 1'b1;
            trap_cause <= 2'b10;
          end
        end
        S_WB:     state <= run ? S_FETCH : S_IDLE;
        S_TRAP:   state <= S_TRAP;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule
